// File: rtl/game_state_controller.sv
// game_state_controller: game sequencer, per-frame hazard hit detection, overlay layer.
// Optional: define GAME_PAUSE_EN for start-toggled pause from PLAY (state 6).
module game_state_controller #(
  parameter int LIVES_INIT   = 3,
  parameter int START_FRAMES = 60,
  parameter int DEATH_FRAMES = 120,
  parameter int HIT_PIXELS   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [9:0]  v_x,
  input  logic [9:0]  v_y,
  input  logic        bright,
  input  logic        bomberman_on,
  input  logic        explosion_on,
  input  logic        enemy_on,
  input  logic        boxes_cleared,
  output logic [2:0]  state,
  output logic        game_over,
  output logic        freeze,
  output logic [2:0]  lives,
  output logic        respawn,
  output logic        overlay_en,
  output logic [11:0] overlay_rgb
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READY = 3'd1,
    S_PLAY  = 3'd2,
    S_DYING = 3'd3,
    S_OVER  = 3'd4,
    S_WIN   = 3'd5
`ifdef GAME_PAUSE_EN
    , S_PAUSED = 3'd6
`endif
  } state_t;

  localparam logic [7:0] START_LAST = 8'(START_FRAMES - 1);
  localparam logic [7:0] DEATH_LAST = 8'(DEATH_FRAMES - 1);
  localparam logic [7:0] HIT_MIN    = 8'(HIT_PIXELS);
  localparam logic [2:0] LIVES_LD   = 3'(LIVES_INIT);

  state_t      state_q;
  state_t      state_d;
  logic [2:0]  lives_d;
  logic        respawn_d;
  logic [7:0]  frame_cnt;
  logic [7:0]  hit_cnt;
  logic        top_q;
  logic        top_qq;
  logic        frame_tick;
  logic        hit;
  logic        hit_px;
  logic        cnt_hold;
  logic        ov_on;
  logic [11:0] ov_col;

  assign state      = state_q;
  assign frame_tick = top_q & ~top_qq;
  assign hit        = (hit_cnt >= HIT_MIN);
  assign hit_px     = bright & bomberman_on & (explosion_on | enemy_on);

  // Top-left compare spans several clocks per pixel; edge gives one tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      top_q  <= 1'b0;
      top_qq <= 1'b0;
    end else begin
      top_q  <= (v_x == 10'd0) && (v_y == 10'd0);
      top_qq <= top_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    lives_d   = lives;
    respawn_d = 1'b0;
    unique case (state_q)
      S_IDLE, S_OVER, S_WIN: begin
        if (start) begin
          state_d   = S_READY;
          lives_d   = LIVES_LD;
          respawn_d = 1'b1;
        end
      end
      S_READY: begin
        if (frame_tick && frame_cnt == START_LAST)
          state_d = S_PLAY;
      end
      S_PLAY: begin
        if (frame_tick && hit)
          state_d = S_DYING;
        else if (frame_tick && boxes_cleared)
          state_d = S_WIN;
`ifdef GAME_PAUSE_EN
        else if (start)
          state_d = S_PAUSED;
`endif
      end
      S_DYING: begin
        if (frame_tick && frame_cnt == DEATH_LAST) begin
          if (lives == 3'd1) begin
            lives_d = 3'd0;
            state_d = S_OVER;
          end else begin
            lives_d   = lives - 3'd1;
            respawn_d = 1'b1;
            state_d   = S_READY;
          end
        end
      end
`ifdef GAME_PAUSE_EN
      S_PAUSED: begin
        if (start)
          state_d = S_PLAY;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      lives     <= 3'd0;
      respawn   <= 1'b0;
      game_over <= 1'b0;
      freeze    <= 1'b1;
    end else begin
      state_q   <= state_d;
      lives     <= lives_d;
      respawn   <= respawn_d;
      game_over <= (state_d == S_OVER);
      freeze    <= (state_d != S_PLAY);
    end
  end

  // Pausing freezes the frame count so PLAY resumes where it left off.
`ifdef GAME_PAUSE_EN
  assign cnt_hold = (state_q == S_PAUSED) || (state_d == S_PAUSED);
`else
  assign cnt_hold = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      frame_cnt <= 8'd0;
    else if (state_d != state_q && !cnt_hold)
      frame_cnt <= 8'd0;
    else if (frame_tick && !cnt_hold && frame_cnt != 8'hFF)
      frame_cnt <= frame_cnt + 8'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      hit_cnt <= 8'd0;
    else if (frame_tick || state_q != S_PLAY)
      hit_cnt <= 8'd0;
    else if (hit_px && hit_cnt != 8'hFF)
      hit_cnt <= hit_cnt + 8'd1;
  end

  always_comb begin
    ov_on  = 1'b0;
    ov_col = 12'h000;
    unique case (state_q)
      S_IDLE:  begin ov_on = 1'b1;         ov_col = 12'h00F; end
      S_DYING: begin ov_on = frame_cnt[3]; ov_col = 12'hFFF; end
      S_OVER:  begin ov_on = 1'b1;         ov_col = 12'hF00; end
      S_WIN:   begin ov_on = 1'b1;         ov_col = 12'h0F0; end
`ifdef GAME_PAUSE_EN
      S_PAUSED: begin ov_on = 1'b1;        ov_col = 12'h444; end
`endif
      default: begin ov_on = 1'b0;         ov_col = 12'h000; end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overlay_en  <= 1'b0;
      overlay_rgb <= 12'h000;
    end else begin
      overlay_en  <= bright & ov_on;
      overlay_rgb <= (bright & ov_on) ? ov_col : 12'h000;
    end
  end

endmodule

// File: tb/tb_game_state_controller.sv
// tb_game_state_controller: randomized frames against a frame-level game model.
// Short synthetic frames; the top-left pixel is held 4 clocks to form each tick.
module tb_game_state_controller;

  localparam int LIVES_INIT   = 3;
  localparam int START_FRAMES = 60;
  localparam int DEATH_FRAMES = 120;
  localparam int HIT_PIXELS   = 16;
  localparam int VIS          = 24;

  localparam int M_IDLE   = 0;
  localparam int M_READY  = 1;
  localparam int M_PLAY   = 2;
  localparam int M_DYING  = 3;
  localparam int M_OVER   = 4;
  localparam int M_WIN    = 5;
  localparam int M_PAUSED = 6;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [9:0]  v_x = 10'd1;
  logic [9:0]  v_y = 10'd1;
  logic        bright = 1'b0;
  logic        bomberman_on = 1'b0;
  logic        explosion_on = 1'b0;
  logic        enemy_on = 1'b0;
  logic        boxes_cleared = 1'b0;
  logic [2:0]  state;
  logic        game_over;
  logic        freeze;
  logic [2:0]  lives;
  logic        respawn;
  logic        overlay_en;
  logic [11:0] overlay_rgb;

  always #5 clk = ~clk;

  game_state_controller dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .v_x           (v_x),
    .v_y           (v_y),
    .bright        (bright),
    .bomberman_on  (bomberman_on),
    .explosion_on  (explosion_on),
    .enemy_on      (enemy_on),
    .boxes_cleared (boxes_cleared),
    .state         (state),
    .game_over     (game_over),
    .freeze        (freeze),
    .lives         (lives),
    .respawn       (respawn),
    .overlay_en    (overlay_en),
    .overlay_rgb   (overlay_rgb)
  );

  int checks = 0;
  int errors = 0;
  int m_st, m_lives, m_f, m_h, exp_rs;
  int rs_seen = 0;
  int rs_bad = 0;
  logic [2:0] prev_state = 3'd0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Respawn must be a lone pulse on the first cycle of a fresh READY.
  always @(negedge clk) begin
    if (respawn) begin
      rs_seen++;
      if (state != 3'd1 || prev_state == 3'd1) rs_bad++;
    end
    prev_state = state;
  end

  task automatic m_go(input int s, input bit keep_f);
    m_st = s;
    m_h  = 0;
    if (!keep_f) m_f = 0;
  endtask

  task automatic m_bump();
    if (m_f < 255) m_f++;
  endtask

  task automatic m_reload();
    m_lives = LIVES_INIT;
    exp_rs++;
    m_go(M_READY, 0);
  endtask

  task automatic m_start();
    case (m_st)
      M_IDLE, M_OVER, M_WIN: m_reload();
`ifdef GAME_PAUSE_EN
      M_PLAY:   m_go(M_PAUSED, 1);
      M_PAUSED: m_go(M_PLAY, 1);
`endif
      default: ;
    endcase
  endtask

  task automatic m_tick(input bit st, input bit bx);
    case (m_st)
      M_IDLE, M_OVER, M_WIN:
        if (st) m_reload(); else m_bump();
      M_READY:
        if (m_f == START_FRAMES - 1) m_go(M_PLAY, 0); else m_bump();
      M_PLAY:
        if (m_h >= HIT_PIXELS) m_go(M_DYING, 0);
        else if (bx) m_go(M_WIN, 0);
`ifdef GAME_PAUSE_EN
        else if (st) m_go(M_PAUSED, 1);
`endif
        else m_bump();
      M_DYING:
        if (m_f == DEATH_FRAMES - 1) begin
          if (m_lives == 1) begin
            m_lives = 0;
            m_go(M_OVER, 0);
          end else begin
            m_lives--;
            exp_rs++;
            m_go(M_READY, 0);
          end
        end else m_bump();
      M_PAUSED:
        if (st) m_go(M_PLAY, 1);
      default: ;
    endcase
    m_h = 0;
  endtask

  function automatic logic [12:0] ov_exp(input int s, input int f,
                                         input logic b);
    logic [12:0] r;
    r = 13'd0;
    if (b) begin
      case (s)
        M_IDLE:   r = {1'b1, 12'h00F};
        M_DYING:  if (f[3]) r = {1'b1, 12'hFFF};
        M_OVER:   r = {1'b1, 12'hF00};
        M_WIN:    r = {1'b1, 12'h0F0};
        M_PAUSED: r = {1'b1, 12'h444};
        default:  r = 13'd0;
      endcase
    end
    return r;
  endfunction

  // n_hit<0: random hits unless playing; st_vis -1 none, -2 random, else index
  task automatic frame(input int n_hit, input bit bx, input int st_vis,
                       input bit st_tick);
    int nh, sv, rem, rs0, s0, r;
    bit hit_now, took;
    logic [12:0] e;
    boxes_cleared = bx;
    for (int j = 0; j < 4; j++) begin
      v_x = 10'd0;
      v_y = 10'd0;
      bright = 1'b0;
      bomberman_on = 1'b0;
      explosion_on = 1'($urandom);
      enemy_on = 1'($urandom);
      start = st_tick && (j == 1);
      @(posedge clk);
      rs0 = exp_rs;
      if (j == 1) m_tick(st_tick, bx);
      @(negedge clk);
      if (j == 1) begin
        chk("tick_state", state, m_st);
        chk("tick_respawn", respawn, (exp_rs != rs0));
      end
    end
    start = 1'b0;
    nh = n_hit;
    if (nh < 0) nh = (m_st == M_PLAY) ? 0 : $urandom_range(0, VIS);
    sv = st_vis;
    if (sv == -2)
      sv = ((m_st == M_READY || m_st == M_DYING) && $urandom_range(0, 2) == 0)
           ? $urandom_range(0, VIS - 1) : -1;
    rem = nh;
    for (int i = 0; i < VIS; i++) begin
      v_x = 10'(i + 1);
      v_y = 10'($urandom_range(1, 479));
      hit_now = (rem > 0) && ($urandom_range(0, VIS - 1 - i) < rem);
      if (hit_now) begin
        rem--;
        bright = 1'b1;
        bomberman_on = 1'b1;
        {explosion_on, enemy_on} = 2'($urandom_range(1, 3));
      end else begin
        r = $urandom_range(0, 3);
        bright       = (r == 1 || r == 2);
        bomberman_on = (r == 0 || r == 2);
        explosion_on = (r == 0) || (r == 1 && 1'($urandom));
        enemy_on     = (r == 0) || (r == 1 && 1'($urandom));
      end
      start = (i == sv);
      @(posedge clk);
      e = ov_exp(m_st, m_f, bright);
      if (m_st == M_PLAY && bright && bomberman_on && (explosion_on || enemy_on))
        m_h++;
      took = 1'b0;
      if (start) begin
        s0 = m_st;
        m_start();
        took = (s0 != m_st) && (m_st == M_READY);
      end
      @(negedge clk);
      chk("overlay_en", overlay_en, e[12]);
      chk("overlay_rgb", overlay_rgb, e[11:0]);
      if (took) begin
        chk("start_state", state, M_READY);
        chk("start_respawn", respawn, 1);
        chk("start_lives", lives, LIVES_INIT);
        chk("start_freeze", freeze, 1);
      end
    end
    start = 1'b0;
    chk("frame_state", state, m_st);
    chk("frame_lives", lives, m_lives);
    chk("frame_freeze", freeze, (m_st != M_PLAY));
    chk("frame_game_over", game_over, (m_st == M_OVER));
  endtask

  task automatic wait_for(input int target, input int cap);
    int n;
    bit st;
    n = 0;
    while (m_st != target && n < cap) begin
      st = (m_st == M_READY || m_st == M_DYING) && ($urandom_range(0, 7) == 0);
      frame(-1, 1'($urandom), -2, st);
      n++;
    end
    chk("reach_state", state, target);
  endtask

  task automatic die();
    frame(HIT_PIXELS + 2, 1'b0, -1, 1'b0);
    frame(0, 1'b0, -1, 1'b0);
    chk("dying", state, M_DYING);
  endtask

  initial begin
    logic [12:0] e;
    m_st = M_IDLE; m_lives = 0; m_f = 0; m_h = 0; exp_rs = 0;
    repeat (3) @(negedge clk);
    chk("rst_state", state, M_IDLE);
    chk("rst_lives", lives, 0);
    chk("rst_game_over", game_over, 0);
    chk("rst_freeze", freeze, 1);
    chk("rst_respawn", respawn, 0);
    chk("rst_overlay_en", overlay_en, 0);
    chk("rst_overlay_rgb", overlay_rgb, 0);
    reset = 1'b0;

    frame(-1, 1'b0, -1, 1'b0);
    frame(-1, 1'b0, -1, 1'b0);
    frame(-1, 1'b0, 5, 1'b0);
    wait_for(M_PLAY, 70);

    frame(HIT_PIXELS - 1, 1'b0, -1, 1'b0);
    frame(HIT_PIXELS, 1'b0, -1, 1'b0);
    chk("below_threshold", state, M_PLAY);
    frame(0, 1'b0, -1, 1'b0);
    chk("at_threshold", state, M_DYING);
    wait_for(M_READY, 130);
    chk("lives_after_1", lives, 2);

    wait_for(M_PLAY, 70);
    frame(20, 1'b0, -1, 1'b0);
    frame(0, 1'b1, -1, 1'b0);
    chk("hit_beats_win", state, M_DYING);
    wait_for(M_READY, 130);
    chk("lives_after_2", lives, 1);

    wait_for(M_PLAY, 70);
    die();
    wait_for(M_OVER, 130);
    chk("over_lives", lives, 0);
    chk("over_flag", game_over, 1);
    frame(-1, 1'b0, -1, 1'b0);
    frame(-1, 1'b0, -1, 1'b1);
    chk("restart_tick", state, M_READY);

    wait_for(M_PLAY, 70);
    frame(0, 1'b1, -1, 1'b0);
    chk("win", state, M_WIN);
    frame(-1, 1'b0, -1, 1'b0);
    frame(-1, 1'b0, 3, 1'b0);

    wait_for(M_PLAY, 70);
    repeat (3) frame(0, 1'b0, -1, 1'b0);
`ifdef GAME_PAUSE_EN
    frame(0, 1'b0, 4, 1'b0);
    chk("paused", state, M_PAUSED);
    repeat (3) frame(-1, 1'b0, -1, 1'b0);
    chk("pause_fcnt", dut.frame_cnt, m_f);
    frame(0, 1'b0, 6, 1'b0);
    chk("resumed", state, M_PLAY);
    chk("resume_fcnt", dut.frame_cnt, m_f);
`else
    frame(0, 1'b0, 4, 1'b0);
    chk("start_in_play", state, M_PLAY);
`endif

    die();
    repeat (44) frame(-1, 1'b0, -1, 1'b0);
    bright = 1'b1;
    bomberman_on = 1'b0;
    @(posedge clk);
    @(negedge clk);
    e = ov_exp(m_st, m_f, 1'b1);
    chk("pre_reset_flash", overlay_en, e[12]);
    #2 reset = 1'b1;
    #1;
    chk("async_state", state, M_IDLE);
    chk("async_lives", lives, 0);
    chk("async_freeze", freeze, 1);
    chk("async_overlay_en", overlay_en, 0);
    chk("async_game_over", game_over, 0);
    @(negedge clk);
    reset = 1'b0;
    bright = 1'b0;
    m_st = M_IDLE; m_lives = 0; m_f = 0; m_h = 0;
    frame(-1, 1'b0, -1, 1'b0);
    frame(-1, 1'b0, 2, 1'b0);

    chk("respawn_pulses", rs_seen, exp_rs);
    chk("respawn_misplaced", rs_bad, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/game_state_controller.md
Name: game_state_controller

Overview:
- Top-level game sequencer: IDLE, READY countdown, PLAY, DYING, GAME_OVER and WIN.
- Detects bomberman-hazard collisions by watching the per-pixel layer enables during each VGA frame.
- Drives game_over, movement freeze, the lives count and a respawn pulse.
- Supplies a full-screen overlay colour layer to the top-level pixel mux.

Parameters:
- LIVES_INIT, 3: lives loaded on start; range 1..7.
- START_FRAMES, 60: frames spent in READY before PLAY.
- DEATH_FRAMES, 120: frames spent in DYING.
- HIT_PIXELS, 16: overlapping pixels within one frame needed to register a hit; range 1..255.

Ports:
- clk, input, 1: system clock, 100 MHz.
- reset, input, 1: asynchronous, active-high.
- start, input, 1: single-cycle pulse from the centre-button debouncer SCEN.
- v_x, input, 10: VGA hCount.
- v_y, input, 10: VGA vCount.
- bright, input, 1: visible-area flag.
- bomberman_on, input, 1: bomberman sprite enable at the current pixel.
- explosion_on, input, 1: explosion sprite enable at the current pixel.
- enemy_on, input, 1: enemy sprite enable at the current pixel.
- boxes_cleared, input, 1: level high when no breakable walls remain.
- state, output, 3: encoded state (IDLE=0, READY=1, PLAY=2, DYING=3, GAME_OVER=4, WIN=5, PAUSED=6).
- game_over, output, 1: high in GAME_OVER.
- freeze, output, 1: high in every state except PLAY; blocks bomberman movement and bomb placement.
- lives, output, 3: remaining lives.
- respawn, output, 1: one-cycle pulse; returns bomberman to its spawn tile.
- overlay_en, output, 1: overlay layer enable.
- overlay_rgb, output, 12: overlay colour.

Behaviour:
- Reset (asynchronous) values:
  - state=IDLE, lives=0, game_over=0, freeze=1, respawn=0, overlay_en=0, overlay_rgb=0.
  - frame_cnt=0, hit_cnt=0.
  - Reset mid-operation aborts everything immediately.
- Frame tick:
  - frame_tick is a one-clk pulse on the rising edge of the registered compare (v_x==0 && v_y==0).
  - The compare holds for 4 clk cycles at 25 MHz pixel rate; edge detection yields exactly one tick per frame.
- Hit counter:
  - In PLAY only, hit_cnt increments each clk where bright & bomberman_on & (explosion_on | enemy_on).
  - Saturates at 255.
  - Cleared on every frame_tick, after evaluation.
  - hit = (hit_cnt >= HIT_PIXELS) sampled at frame_tick.
- frame_cnt (8 bit):
  - Cleared on every state entry.
  - Incremented on frame_tick; saturates at 255.
- Transitions (all evaluated at frame_tick unless stated):
  - IDLE -> READY on start (any cycle): lives<=LIVES_INIT, respawn pulse.
  - READY -> PLAY when frame_cnt==START_FRAMES-1.
  - PLAY -> DYING on hit; PLAY -> WIN on boxes_cleared.
  - PLAY, hit and boxes_cleared on the same tick: DYING wins.
  - DYING exit, when frame_cnt==DEATH_FRAMES-1:
    - lives==1: lives<=0, go to GAME_OVER.
    - otherwise: lives<=lives-1, respawn pulse, go to READY.
  - GAME_OVER or WIN -> READY on start: lives reload, respawn pulse.
  - start in READY or DYING: ignored.
  - start coincident with frame_tick in IDLE/GAME_OVER/WIN: start taken.
- respawn: exactly one clk, in the same cycle the state register changes.
- game_over and freeze are registered and decoded from the next state, so they change in the same cycle as state.
- Overlay, registered, 1-cycle latency from bright:
  - overlay_en = bright & (state in {IDLE, DYING-flash, GAME_OVER, WIN, PAUSED}).
  - IDLE: 12'h00F.
  - DYING: 12'hFFF when frame_cnt[3]==1, else overlay_en=0.
  - GAME_OVER: 12'hF00.
  - WIN: 12'h0F0.
  - PAUSED: 12'h444.
  - READY and PLAY: overlay_en=0.

Optional Feature:
- Macro: GAME_PAUSE_EN.
- Defined:
  - start in PLAY -> PAUSED; start in PAUSED -> PLAY.
  - PAUSED: freeze=1, hit_cnt held at 0, frame_cnt unchanged; PLAY frame_cnt resumes on return.
  - Encoding 6 used.
- Undefined:
  - start in PLAY ignored.
  - PAUSED state and encoding 6 absent; state never equals 6.

Test Plan:
- Reset then start pulse -> state IDLE->READY next clk, lives=3, respawn high for exactly 1 clk, freeze=1.
- After 60 frame ticks in READY -> state=PLAY, freeze=0, overlay_en=0.
- In PLAY, drive bomberman_on&explosion_on for 16 visible clks in one frame -> DYING at the next tick. With 15 clks -> stays PLAY.
- Three deaths from LIVES_INIT=3 -> lives 3->2->1 with respawn pulses; third DYING expiry -> GAME_OVER, game_over=1, lives=0, overlay_rgb=12'hF00 while bright.
- In PLAY, hit and boxes_cleared on the same frame -> DYING, not WIN. Separately, boxes_cleared alone -> WIN with overlay 12'h0F0.
- Assert reset mid-DYING -> state=IDLE, lives=0, freeze=1, overlay_en=0 asynchronously. With GAME_PAUSE_EN, start in PLAY -> PAUSED (6), and a second start returns to PLAY with frame_cnt unchanged.
